// File: rtl/veerwolf_uart_pkg.sv
// Shared types and constants for the VeeRwolf UART receive path.
package veerwolf_uart_pkg;

    localparam int unsigned DATA_BITS            = 8;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind the UART receiver: registered write, head word always presented.
module uart_rx_fifo
    import veerwolf_uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] push_data,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] head_data,
    output logic                 valid,
    output logic                 overrun
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

    logic empty_c;
    logic full_c;
    logic do_pop_c;
    logic do_push_c;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign empty_c   = (wr_ptr == rd_ptr);
    assign full_c    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_pop_c  = pop && !empty_c;
    assign do_push_c = push && (!full_c || do_pop_c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            overrun <= push && full_c && !do_pop_c;
            if (do_push_c) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    assign valid     = !empty_c;
    assign head_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_decoder.sv
// 8N1 UART receiver: line synchronizer, bit-timing FSM and output byte FIFO.
module uart_rx_decoder
    import veerwolf_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_serial_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    logic                 sync1;
    logic                 rxs;
    rx_state_e            state;
    rx_state_e            state_next;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_next;
    logic [IW-1:0]        idx;
    logic [IW-1:0]        idx_next;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_next;
    logic                 busy_next;
    logic                 push_c;
    logic                 frame_err_c;

    // Synchronizer idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= i_serial_rx;
            rxs   <= sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= WAIT_IDLE;
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            o_busy      <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            idx         <= idx_next;
            shift       <= shift_next;
            o_busy      <= busy_next;
            o_frame_err <= frame_err_c;
        end
    end

    // WAIT_IDLE reuses the baud counter to count consecutive high cycles.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        shift_next = shift;
        case (state)
            WAIT_IDLE: begin
                if (!rxs) begin
                    cnt_next = '0;
                end else if (cnt == CNT_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            IDLE: begin
                if (!rxs) begin
                    cnt_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = rxs ? IDLE : DATA;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_next        = '0;
                    shift_next[idx] = rxs;
                    if (idx == IDX_LAST) begin
                        state_next = STOP;
                    end else begin
                        idx_next = idx + IW'(1);
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_next   = '0;
                    state_next = rxs ? IDLE : WAIT_IDLE;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = WAIT_IDLE;
            end
        endcase
    end

    always_comb begin
        push_c      = 1'b0;
        frame_err_c = 1'b0;
        busy_next   = (state_next == START) || (state_next == DATA) || (state_next == STOP);
        if (state == STOP && cnt == CNT_LAST) begin
            push_c      = rxs;
            frame_err_c = !rxs;
        end
    end

    uart_rx_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_c),
        .push_data(shift),
        .pop      (o_valid && i_ready),
        .head_data(o_data),
        .valid    (o_valid),
        .overrun  (o_overrun)
    );

endmodule

// File: tb/tb_uart_rx_decoder.sv
// Scenario bench for uart_rx_decoder against a queue-level reference model.
module tb_uart_rx_decoder;

    localparam int unsigned CPB   = 16;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       i_ready = 1'b0;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_overrun;
    logic       o_busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] got[$];
    int fe_cnt = 0, ov_cnt = 0, wide_cnt = 0, busy_cyc = 0, unstable = 0;
    logic prev_fe = 1'b0, prev_ov = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0;
    logic [7:0] prev_data = '0;

    always #5 clk = ~clk;

    uart_rx_decoder #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_serial_rx(rx),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_frame_err(o_frame_err),
        .o_overrun  (o_overrun),
        .o_busy     (o_busy)
    );

    // Observer on the falling edge: records handshakes, pulses and busy time.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_fe    = 1'b0;
            prev_ov    = 1'b0;
        end else begin
            if (o_valid && i_ready) got.push_back(o_data);
            if (o_frame_err) fe_cnt++;
            if (o_overrun) ov_cnt++;
            if ((o_frame_err && prev_fe) || (o_overrun && prev_ov)) wide_cnt++;
            if (o_busy) busy_cyc++;
            if (prev_valid && !prev_ready && o_data !== prev_data) unstable++;
            prev_fe    = o_frame_err;
            prev_ov    = o_overrun;
            prev_valid = o_valid;
            prev_ready = i_ready;
            prev_data  = o_data;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [9:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            rx = f[i];
            tick(CPB);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        send_frame({stop_bit, b, 1'b0}, 10);
        rx = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; rx = 1'b1; i_ready = 1'b0;
        tick(3);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
        checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", o_data); end
        checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", o_frame_err); end
        checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", o_overrun); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
        rst = 1'b0;
        tick(CPB + 4);
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp[$];
        int base = got.size();
        int fe0 = fe_cnt, ov0 = ov_cnt;
        exp = '{8'h55, 8'hA3, 8'h00, 8'hFF};
        for (int i = 0; i < 4; i++) exp.push_back(8'($urandom_range(0, 255)));
        i_ready = 1'b1;
        foreach (exp[i]) send_byte(exp[i], 1'b1);
        tick(20);
        checks++; if (got.size() - base != exp.size()) begin errors++; $display("FAIL b2b_count got %0d want %0d", got.size() - base, exp.size()); end
        foreach (exp[i]) if (base + i < got.size()) begin
            checks++; if (got[base+i] !== exp[i]) begin errors++; $display("FAIL b2b_byte%0d got %h want %h", i, got[base+i], exp[i]); end
        end
        checks++; if (fe_cnt != fe0 || ov_cnt != ov0) begin errors++; $display("FAIL b2b_pulses got fe %0d ov %0d want 0 0", fe_cnt - fe0, ov_cnt - ov0); end
    endtask

    task automatic test_low_through_reset;
        int base, b0;
        rst = 1'b1; rx = 1'b0; i_ready = 1'b1;
        tick(3);
        rst = 1'b0;
        base = got.size(); b0 = busy_cyc;
        tick(50);
        rx = 1'b1; tick(10);
        rx = 1'b0; tick(3);
        rx = 1'b1; tick(8);
        // Fewer than CPB consecutive highs precede this frame, so it must be ignored.
        send_byte(8'hF0, 1'b1);
        tick(10);
        checks++; if (got.size() != base) begin errors++; $display("FAIL wait_idle_bytes got %0d want 0", got.size() - base); end
        checks++; if (busy_cyc != b0) begin errors++; $display("FAIL wait_idle_busy got %0d want 0", busy_cyc - b0); end
        send_byte(8'h3C, 1'b1);
        tick(20);
        checks++; if (got.size() != base + 1) begin errors++; $display("FAIL after_idle_count got %0d want 1", got.size() - base); end
        else begin
            checks++; if (got[base] !== 8'h3C) begin errors++; $display("FAIL after_idle_byte got %h want 3c", got[base]); end
        end
    endtask

    task automatic test_glitch;
        int base = got.size(), b0 = busy_cyc, fe0 = fe_cnt, ov0 = ov_cnt;
        rx = 1'b0; tick(4);
        rx = 1'b1; tick(3 * CPB);
        checks++; if (busy_cyc - b0 != CPB / 2) begin errors++; $display("FAIL glitch_busy got %0d want %0d", busy_cyc - b0, CPB / 2); end
        checks++; if (got.size() != base) begin errors++; $display("FAIL glitch_bytes got %0d want 0", got.size() - base); end
        checks++; if (fe_cnt != fe0 || ov_cnt != ov0) begin errors++; $display("FAIL glitch_pulses got fe %0d ov %0d want 0 0", fe_cnt - fe0, ov_cnt - ov0); end
    endtask

    task automatic test_frame_error;
        int base = got.size(), fe0 = fe_cnt, ov0 = ov_cnt, w0 = wide_cnt;
        i_ready = 1'b1;
        send_byte(8'h81, 1'b0);
        tick(40);
        checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL frame_err_pulses got %0d want 1", fe_cnt - fe0); end
        checks++; if (wide_cnt != w0) begin errors++; $display("FAIL frame_err_width got %0d wide want 0", wide_cnt - w0); end
        checks++; if (got.size() != base || o_valid !== 1'b0) begin errors++; $display("FAIL frame_err_fifo got %0d bytes valid %b want 0 0", got.size() - base, o_valid); end
        send_byte(8'h42, 1'b1);
        tick(20);
        checks++; if (got.size() != base + 1) begin errors++; $display("FAIL post_err_count got %0d want 1", got.size() - base); end
        else begin
            checks++; if (got[base] !== 8'h42) begin errors++; $display("FAIL post_err_byte got %h want 42", got[base]); end
        end
        checks++; if (ov_cnt != ov0) begin errors++; $display("FAIL frame_err_overrun got %0d want 0", ov_cnt - ov0); end
    endtask

    task automatic test_overrun;
        logic [7:0] mq[$];
        int exp_ov = 0;
        int base = got.size(), ov0 = ov_cnt, w0 = wide_cnt, u0 = unstable;
        i_ready = 1'b0;
        for (int b = 1; b <= 5; b++) begin
            if (mq.size() < DEPTH) mq.push_back(8'(b)); else exp_ov++;
            send_byte(8'(b), 1'b1);
        end
        tick(20);
        checks++; if (ov_cnt - ov0 != exp_ov) begin errors++; $display("FAIL overrun_pulses got %0d want %0d", ov_cnt - ov0, exp_ov); end
        checks++; if (wide_cnt != w0) begin errors++; $display("FAIL overrun_width got %0d wide want 0", wide_cnt - w0); end
        checks++; if (o_valid !== 1'b1 || o_data !== mq[0]) begin errors++; $display("FAIL overrun_head got v%b %h want v1 %h", o_valid, o_data, mq[0]); end
        i_ready = 1'b1; tick(10); i_ready = 1'b0;
        checks++; if (got.size() - base != mq.size()) begin errors++; $display("FAIL overrun_drain_count got %0d want %0d", got.size() - base, mq.size()); end
        foreach (mq[i]) if (base + i < got.size()) begin
            checks++; if (got[base+i] !== mq[i]) begin errors++; $display("FAIL overrun_drain%0d got %h want %h", i, got[base+i], mq[i]); end
        end
        checks++; if (unstable != u0) begin errors++; $display("FAIL stall_stability got %0d changes want 0", unstable - u0); end
    endtask

    task automatic test_full_push_pop;
        logic [7:0] mq[$];
        logic [7:0] hs[$];
        int base = got.size(), ov0 = ov_cnt;
        i_ready = 1'b0;
        for (int b = 1; b <= 4; b++) begin
            if (mq.size() < DEPTH) mq.push_back(8'(b));
            send_byte(8'(b), 1'b1);
        end
        hs.push_back(mq.pop_front());
        mq.push_back(8'h05);
        // Stop-bit sample of a frame falls 154 cycles after its start-bit drive.
        fork
            send_byte(8'h05, 1'b1);
            begin
                tick(9 * CPB + 10);
                i_ready = 1'b1;
                tick(1);
                i_ready = 1'b0;
            end
        join
        tick(5);
        checks++; if (ov_cnt != ov0) begin errors++; $display("FAIL full_pushpop_overrun got %0d want 0", ov_cnt - ov0); end
        checks++; if (o_data !== mq[0]) begin errors++; $display("FAIL full_pushpop_head got %h want %h", o_data, mq[0]); end
        i_ready = 1'b1; tick(10); i_ready = 1'b0;
        foreach (mq[i]) hs.push_back(mq[i]);
        checks++; if (got.size() - base != hs.size()) begin errors++; $display("FAIL full_pushpop_count got %0d want %0d", got.size() - base, hs.size()); end
        foreach (hs[i]) if (base + i < got.size()) begin
            checks++; if (got[base+i] !== hs[i]) begin errors++; $display("FAIL full_pushpop%0d got %h want %h", i, got[base+i], hs[i]); end
        end
    endtask

    task automatic test_random_ready;
        logic [7:0] exp[$];
        int base = got.size(), ov0 = ov_cnt, u0 = unstable;
        for (int i = 0; i < 6; i++) exp.push_back(8'($urandom_range(0, 255)));
        fork
            foreach (exp[i]) send_byte(exp[i], 1'b1);
            begin
                repeat (6 * 10 * CPB + 20) begin
                    i_ready = 1'($urandom_range(0, 1));
                    tick(1);
                end
            end
        join
        i_ready = 1'b1; tick(10);
        checks++; if (got.size() - base != exp.size()) begin errors++; $display("FAIL rand_ready_count got %0d want %0d", got.size() - base, exp.size()); end
        foreach (exp[i]) if (base + i < got.size()) begin
            checks++; if (got[base+i] !== exp[i]) begin errors++; $display("FAIL rand_ready%0d got %h want %h", i, got[base+i], exp[i]); end
        end
        checks++; if (ov_cnt != ov0 || unstable != u0) begin errors++; $display("FAIL rand_ready_misc got ov %0d unstable %0d want 0 0", ov_cnt - ov0, unstable - u0); end
    endtask

    task automatic test_midframe_reset;
        int base;
        i_ready = 1'b0;
        send_byte(8'h11, 1'b1);
        tick(5);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %b want 1", o_valid); end
        send_frame({1'b1, 8'h77, 1'b0}, 4);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy got %b want 1", o_busy); end
        rst = 1'b1;
        #1;
        checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL midreset_state got v%b busy%b want 0 0", o_valid, o_busy); end
        checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL midreset_data got %h want 00", o_data); end
        tick(2);
        rst = 1'b0; rx = 1'b1;
        tick(CPB + 4);
        i_ready = 1'b1;
        base = got.size();
        send_byte(8'h19, 1'b1);
        tick(20);
        checks++; if (got.size() != base + 1) begin errors++; $display("FAIL post_reset_count got %0d want 1", got.size() - base); end
        else begin
            checks++; if (got[base] !== 8'h19) begin errors++; $display("FAIL post_reset_byte got %h want 19", got[base]); end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_low_through_reset();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_full_push_pop();
        test_random_ready();
        test_midframe_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_decoder.md
Name: uart_rx_decoder

Overview:
- 8N1 UART receiver: the receive-side counterpart of the SoC's o_serial_tx transmitter.
- Decodes a serial line into bytes and buffers them in a small FIFO with a valid/ready output.
- Used in the Nexys Video bench to capture and check console output.
- Also instantiable in RTL as the i_serial_rx front end.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit (100 MHz / 115200 baud); must be >= 8.
- FIFO_DEPTH, 4, byte FIFO entries; must be a power of two, >= 2.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- i_serial_rx  input  1  serial line, idle high, asynchronous to clk
- o_data  output  8  byte at FIFO head
- o_valid  output  1  FIFO non-empty
- i_ready  input  1  consumer accepts o_data when o_valid && i_ready
- o_frame_err  output  1  one-cycle pulse: stop bit sampled low
- o_overrun  output  1  one-cycle pulse: byte dropped because FIFO full
- o_busy  output  1  high in START, DATA or STOP state

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0; FIFO is empty.
  - Both synchronizer flops reset to 1.
  - FSM enters WAIT_IDLE.
- Input sync: two-flop synchronizer; rxs is the second flop. Line-to-rxs latency is 2 cycles.
- Baud counter is $clog2(CLKS_PER_BIT) bits wide. Bit index is 3 bits. Data shifts in LSB first.
- FSM transitions:
  - WAIT_IDLE: count consecutive rxs==1 cycles; any 0 clears the count. At CLKS_PER_BIT consecutive highs -> IDLE. This prevents decoding a frame already in progress after reset, and handles a break condition.
  - IDLE: rxs==0 -> START, counter cleared.
  - START: at count == CLKS_PER_BIT/2-1 (mid start bit), sample rxs:
    - 1 -> false start, return to IDLE with no pulse.
    - 0 -> DATA, counter cleared, bit index 0.
  - DATA: at count == CLKS_PER_BIT-1, sample rxs into shift[idx] and clear the counter. After bit 7 -> STOP.
  - STOP: at count == CLKS_PER_BIT-1, sample rxs:
    - 1 -> push byte, go to IDLE. A back-to-back start bit is detected from the following cycle.
    - 0 -> o_frame_err pulses in the next cycle, byte discarded, go to WAIT_IDLE.
- Push timing: the byte is visible on o_data/o_valid one cycle after the stop sample (registered FIFO write).
- FIFO: pointers are log2(FIFO_DEPTH)+1 bits with wrap bit.
  - Empty when pointers are equal; full when the index bits are equal and the wrap bits differ.
  - Pop happens on o_valid && i_ready.
  - Pop with empty FIFO: ignored.
  - Push with FIFO full and no pop in the same cycle: byte dropped, o_overrun pulses once, FIFO contents unchanged.
  - Push and pop in the same cycle with FIFO full: both happen, no overrun, occupancy unchanged.
  - Push and pop in the same cycle with FIFO empty: push only, o_valid rises next cycle (no bypass).
- o_data holds the head entry and is stable while o_valid && !i_ready.
- Reset mid-frame: partial byte discarded, FIFO flushed, FSM restarts in WAIT_IDLE.
- o_frame_err and o_overrun can assert in the same cycle only if they come from distinct events; each is exactly one cycle wide.

Decomposition:
- Package veerwolf_uart_pkg holds:
  - the FSM state enum: WAIT_IDLE, IDLE, START, DATA, STOP;
  - localparams DATA_BITS=8 and DEFAULT_CLKS_PER_BIT=868.
- Sub-module uart_rx_fifo holds the parameterised synchronous FIFO: push/pop, full/empty, head data. The top holds the synchronizer, counters and FSM.

Test Plan:
- Bench parameters for all scenarios: CLKS_PER_BIT=16, FIFO_DEPTH=4.
- Idle line after reset, then bytes 0x55, 0xA3, 0x00, 0xFF back-to-back with i_ready=1 -> four o_valid handshakes in order with exactly those values; no error pulses.
- Line held low through reset release, then released high mid-frame -> no byte until 16 consecutive high cycles; a following frame 0x3C decodes as 0x3C.
- Glitch low for 4 cycles (shorter than half a bit) -> no o_busy beyond START, no byte, no pulses.
- Frame 0x81 with stop bit driven low -> o_frame_err one cycle, FIFO unchanged; a subsequent valid 0x42 after 16+ idle cycles -> 0x42 delivered.
- i_ready=0, send 0x01..0x05 -> FIFO holds 0x01..0x04, o_overrun pulses once on 0x05; draining yields 0x01..0x04 only.
- FIFO full with i_ready pulsed in the same cycle as the 5th push -> no overrun; draining yields 0x02..0x05.
- Assert rst during DATA of 0x77 -> o_valid=0, FIFO empty, o_busy=0 immediately; next clean frame 0x19 decodes correctly.
